// File: rtl/nway_cache_control_pkg.sv
// Shared types for the N-way cache controller: FSM state encoding and limits.
package lc3b_types;

  // Controller FSM states.
  typedef enum logic [1:0] {
    S_COMPARE   = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FILL      = 2'd2
  } cache_state_t;

  // Largest associativity the PLRU tree and encoders are meant for.
  localparam int MAX_WAYS = 8;

endpackage

// File: rtl/nway_cache_control_plru_tree.sv
// Combinational tree pseudo-LRU: victim lookup and access update.
// Node 0 is the root; node i has children 2i+1 (lower half) and 2i+2
// (upper half). A node value of 0 points the victim at the lower half.
module plru_tree #(
  parameter  int WAYS  = 4,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  plru_out,
  input  logic [WAY_W-1:0] access_way,
  output logic [WAY_W-1:0] victim,
  output logic [WAYS-2:0]  plru_in
);

  // Follow the node bits from the root down to the victim leaf.
  always_comb begin : walk_victim
    int node;
    node   = 0;
    victim = '0;
    for (int l = 0; l < WAY_W; l++) begin
      victim[WAY_W-1-l] = plru_out[node];
      node = 2 * node + 1 + int'(plru_out[node]);
    end
  end

  // Point every node on the accessed way's path away from that way.
  always_comb begin : walk_update
    int node;
    logic dir;
    node    = 0;
    dir     = 1'b0;
    plru_in = plru_out;
    for (int l = 0; l < WAY_W; l++) begin
      dir           = access_way[WAY_W-1-l];
      plru_in[node] = ~dir;
      node = 2 * node + 1 + int'(dir);
    end
  end

endmodule

// File: rtl/nway_cache_control.sv
// N-way set-associative write-back / write-allocate cache controller.
// Request/response protocol: a CPU request (mem_read or mem_write, write wins
// when both are high) is held by the CPU until mem_resp is seen high in the
// same cycle; a pmem request (pmem_read or pmem_write, never both) is held by
// this controller until the cycle pmem_resp is sampled high, then dropped.
module nway_cache_control
  import lc3b_types::*;
#(
  parameter  int WAYS  = 4,
  parameter  int CNT_W = 16,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_read,
  input  logic               mem_write,
  output logic               mem_resp,
  output logic               pmem_read,
  output logic               pmem_write,
  input  logic               pmem_resp,
  input  logic [WAYS-1:0]    match,
  input  logic [WAYS-1:0]    valid_out,
  input  logic [WAYS-1:0]    dirty_out,
  input  logic [WAYS-2:0]    plru_out,
  output logic [WAYS-2:0]    plru_in,
  output logic               plru_load,
  output logic [WAYS-1:0]    data_load,
  output logic [WAYS-1:0]    tag_load,
  output logic [WAYS-1:0]    valid_load,
  output logic [WAYS-1:0]    dirty_load,
  output logic               valid_in,
  output logic               dirty_in,
  output logic [WAY_W-1:0]   way_sel,
  output logic               write_array_sel,
  output logic               pmem_address_sel,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   miss_count,
  output cache_state_t       state_dbg
);

  cache_state_t     r_state;
  logic [WAY_W-1:0] r_victim_q;
  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_miss_count;

  logic             w_req;
  logic [WAYS-1:0]  w_hit_vec;
  logic             w_hit;
  logic             w_any_inv;
  logic [WAY_W-1:0] w_hit_way;
  logic [WAY_W-1:0] w_inv_way;
  logic [WAY_W-1:0] w_plru_victim;
  logic [WAY_W-1:0] w_victim;
  logic             w_victim_dirty;
  logic [WAY_W-1:0] w_access_way;
  logic [WAYS-2:0]  w_plru_next;
  logic [WAYS-1:0]  w_hit_oh;
  logic [WAYS-1:0]  w_vq_oh;

  // A matching but invalid way is a miss, so qualify the tag compare.
  assign w_req     = mem_read | mem_write;
  assign w_hit_vec = match & valid_out;
  assign w_hit     = |w_hit_vec;
  assign w_any_inv = ~&valid_out;

  // Lowest-index hitting way and lowest-index invalid way.
  always_comb begin
    w_hit_way = '0;
    w_inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) w_hit_way = WAY_W'(i);
      if (!valid_out[i]) w_inv_way = WAY_W'(i);
    end
  end

  // Filling an empty way never costs a writeback, so invalid ways win.
  assign w_victim       = w_any_inv ? w_inv_way : w_plru_victim;
  assign w_victim_dirty = valid_out[w_victim] & dirty_out[w_victim];

  // The single tree update serves the hit way on a hit, the latched victim on a fill.
  assign w_access_way = (r_state == S_COMPARE) ? w_hit_way : r_victim_q;
  assign w_hit_oh     = WAYS'(1) << w_hit_way;
  assign w_vq_oh      = WAYS'(1) << r_victim_q;

  plru_tree #(.WAYS(WAYS)) u_plru_tree (
    .plru_out   (plru_out),
    .access_way (w_access_way),
    .victim     (w_plru_victim),
    .plru_in    (w_plru_next)
  );

  // Outputs decode from state and inputs; everything is forced low in reset.
  always_comb begin
    mem_resp         = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    plru_in          = '0;
    plru_load        = 1'b0;
    data_load        = '0;
    tag_load         = '0;
    valid_load       = '0;
    dirty_load       = '0;
    valid_in         = 1'b0;
    dirty_in         = 1'b0;
    way_sel          = '0;
    write_array_sel  = 1'b0;
    pmem_address_sel = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_COMPARE: begin
          if (w_req && w_hit) begin
            mem_resp  = 1'b1;
            way_sel   = w_hit_way;
            plru_load = 1'b1;
            plru_in   = w_plru_next;
            if (mem_write) begin
              data_load       = w_hit_oh;
              write_array_sel = 1'b0;
              dirty_in        = 1'b1;
              dirty_load      = w_hit_oh;
            end
          end
        end
        S_WRITEBACK: begin
          pmem_write       = 1'b1;
          pmem_address_sel = 1'b1;
          way_sel          = r_victim_q;
        end
        S_FILL: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            tag_load        = w_vq_oh;
            data_load       = w_vq_oh;
            valid_load      = w_vq_oh;
            dirty_load      = w_vq_oh;
            write_array_sel = 1'b1;
            valid_in        = 1'b1;
            dirty_in        = 1'b0;
            plru_load       = 1'b1;
            plru_in         = w_plru_next;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM, latched victim and saturating hit/miss counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_COMPARE;
      r_victim_q   <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      case (r_state)
        S_COMPARE: begin
          if (w_req) begin
            if (w_hit) begin
              if (r_hit_count != '1) r_hit_count <= r_hit_count + CNT_W'(1);
            end else begin
              r_victim_q <= w_victim;
              if (r_miss_count != '1) r_miss_count <= r_miss_count + CNT_W'(1);
              r_state <= w_victim_dirty ? S_WRITEBACK : S_FILL;
            end
          end
        end
        S_WRITEBACK: if (pmem_resp) r_state <= S_FILL;
        S_FILL:      if (pmem_resp) r_state <= S_COMPARE;
        default:     r_state <= S_COMPARE;
      endcase
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_nway_cache_control.sv
// Directed bench for nway_cache_control (WAYS=4), with a second CNT_W=2
// instance sharing the same stimulus to exercise counter saturation.
module tb_nway_cache_control;
  import lc3b_types::*;

  localparam int OUT_W = 31;

  typedef struct packed {
    logic       mem_resp;
    logic       pmem_read;
    logic       pmem_write;
    logic       pmem_address_sel;
    logic       write_array_sel;
    logic       valid_in;
    logic       dirty_in;
    logic       plru_load;
    logic [2:0] plru_in;
    logic [1:0] way_sel;
    logic [3:0] data_load;
    logic [3:0] tag_load;
    logic [3:0] valid_load;
    logic [3:0] dirty_load;
    logic [1:0] state;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_read, mem_write, pmem_resp;
  logic [3:0] match, valid_out, dirty_out;
  logic [2:0] plru_out;

  logic mem_resp, pmem_read, pmem_write, plru_load, valid_in, dirty_in;
  logic write_array_sel, pmem_address_sel;
  logic [2:0] plru_in;
  logic [3:0] data_load, tag_load, valid_load, dirty_load;
  logic [1:0] way_sel;
  logic [15:0] hit_count, miss_count;
  cache_state_t state_dbg;

  logic s_mem_resp, s_pmem_read, s_pmem_write, s_plru_load, s_valid_in, s_dirty_in;
  logic s_write_array_sel, s_pmem_address_sel;
  logic [2:0] s_plru_in;
  logic [3:0] s_data_load, s_tag_load, s_valid_load, s_dirty_load;
  logic [1:0] s_way_sel;
  logic [1:0] s_hit_count, s_miss_count;
  cache_state_t s_state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_hits, exp_misses;
  logic [OUT_W-1:0] exp_q[$];
  outs_t e;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  nway_cache_control #(.WAYS(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .match(match), .valid_out(valid_out),
    .dirty_out(dirty_out), .plru_out(plru_out), .plru_in(plru_in),
    .plru_load(plru_load), .data_load(data_load), .tag_load(tag_load),
    .valid_load(valid_load), .dirty_load(dirty_load), .valid_in(valid_in),
    .dirty_in(dirty_in), .way_sel(way_sel), .write_array_sel(write_array_sel),
    .pmem_address_sel(pmem_address_sel), .hit_count(hit_count),
    .miss_count(miss_count), .state_dbg(state_dbg)
  );

  nway_cache_control #(.WAYS(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(s_mem_resp), .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
    .pmem_resp(pmem_resp), .match(match), .valid_out(valid_out),
    .dirty_out(dirty_out), .plru_out(plru_out), .plru_in(s_plru_in),
    .plru_load(s_plru_load), .data_load(s_data_load), .tag_load(s_tag_load),
    .valid_load(s_valid_load), .dirty_load(s_dirty_load), .valid_in(s_valid_in),
    .dirty_in(s_dirty_in), .way_sel(s_way_sel), .write_array_sel(s_write_array_sel),
    .pmem_address_sel(s_pmem_address_sel), .hit_count(s_hit_count),
    .miss_count(s_miss_count), .state_dbg(s_state_dbg)
  );

  // Reference PLRU touch for a 4-way tree, written as a per-way table.
  function automatic logic [2:0] plru_touch4(input logic [2:0] bits, input int way);
    logic [2:0] r;
    r = bits;
    case (way)
      0: begin r[0] = 1'b1; r[1] = 1'b1; end
      1: begin r[0] = 1'b1; r[1] = 1'b0; end
      2: begin r[0] = 1'b0; r[2] = 1'b1; end
      default: begin r[0] = 1'b0; r[2] = 1'b0; end
    endcase
    return r;
  endfunction

  function automatic logic [3:0] oh4(input int way);
    logic [3:0] r;
    r = '0;
    r[way] = 1'b1;
    return r;
  endfunction

  function automatic outs_t cur();
    outs_t o;
    o.mem_resp         = mem_resp;
    o.pmem_read        = pmem_read;
    o.pmem_write       = pmem_write;
    o.pmem_address_sel = pmem_address_sel;
    o.write_array_sel  = write_array_sel;
    o.valid_in         = valid_in;
    o.dirty_in         = dirty_in;
    o.plru_load        = plru_load;
    o.plru_in          = plru_in;
    o.way_sel          = way_sel;
    o.data_load        = data_load;
    o.tag_load         = tag_load;
    o.valid_load       = valid_load;
    o.dirty_load       = dirty_load;
    o.state            = state_dbg;
    return o;
  endfunction

  // scoreboard helpers
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input outs_t x);
    exp_q.push_back(x);
  endtask

  task automatic sample_out(input string tag);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      check(tag, 64'(cur()), 64'(exp_q.pop_front()));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag);
    sample_out(tag);
    tick();
  endtask

  task automatic check_counts(input string tag);
    int sat_h, sat_m;
    sat_h = (exp_hits > 3) ? 3 : exp_hits;
    sat_m = (exp_misses > 3) ? 3 : exp_misses;
    check({tag, "_hit_count"}, 64'(hit_count), 64'(exp_hits));
    check({tag, "_miss_count"}, 64'(miss_count), 64'(exp_misses));
    check({tag, "_sat_hit_count"}, 64'(s_hit_count), 64'(sat_h));
    check({tag, "_sat_miss_count"}, 64'(s_miss_count), 64'(sat_m));
  endtask

  // driver tasks building expected output vectors
  task automatic exp_idle(input cache_state_t st);
    e = '0;
    e.state = st;
    push_exp(e);
  endtask

  task automatic exp_hit(input int way, input logic wr, input logic [2:0] plru);
    e = '0;
    e.mem_resp  = 1'b1;
    e.way_sel   = 2'(way);
    e.plru_load = 1'b1;
    e.plru_in   = plru;
    if (wr) begin
      e.data_load  = oh4(way);
      e.dirty_load = oh4(way);
      e.dirty_in   = 1'b1;
    end
    e.state = S_COMPARE;
    push_exp(e);
  endtask

  task automatic exp_wb(input int way);
    e = '0;
    e.pmem_write       = 1'b1;
    e.pmem_address_sel = 1'b1;
    e.way_sel          = 2'(way);
    e.state            = S_WRITEBACK;
    push_exp(e);
  endtask

  task automatic exp_fill_wait();
    e = '0;
    e.pmem_read = 1'b1;
    e.state     = S_FILL;
    push_exp(e);
  endtask

  task automatic exp_fill_done(input int way, input logic [2:0] plru);
    e = '0;
    e.pmem_read       = 1'b1;
    e.tag_load        = oh4(way);
    e.data_load       = oh4(way);
    e.valid_load      = oh4(way);
    e.dirty_load      = oh4(way);
    e.write_array_sel = 1'b1;
    e.valid_in        = 1'b1;
    e.plru_load       = 1'b1;
    e.plru_in         = plru;
    e.state           = S_FILL;
    push_exp(e);
  endtask

  initial begin
    exp_hits = 0;
    exp_misses = 0;
    rst_n = 1'b0;
    mem_read = 1'b1; mem_write = 1'b0; pmem_resp = 1'b0;
    match = 4'b0001; valid_out = 4'b0001; dirty_out = 4'b0000; plru_out = 3'b000;

    // reset: a hitting request is present, yet every output stays low
    exp_idle(S_COMPARE);
    sample_out("reset_outputs");
    check_counts("reset");
    tick();
    rst_n = 1'b1;

    // all ways invalid, read miss -> way 0, fill answered on the 3rd cycle
    match = 4'b0000; valid_out = 4'b0000; plru_out = 3'b000;
    exp_idle(S_COMPARE); step("t1_miss_cycle"); exp_misses++;
    for (int i = 0; i < 2; i++) begin
      exp_fill_wait(); step("t1_fill_wait");
    end
    pmem_resp = 1'b1;
    exp_fill_done(0, plru_touch4(3'b000, 0)); step("t1_fill_resp");
    pmem_resp = 1'b0;
    match = 4'b0001; valid_out = 4'b0001; plru_out = 3'b011;
    exp_hit(0, 1'b0, plru_touch4(3'b011, 0)); step("t1_read_hit"); exp_hits++;
    check_counts("t1");

    // full set, PLRU -> way 0, way 0 dirty, write miss -> writeback then fill
    mem_read = 1'b0; mem_write = 1'b1;
    match = 4'b0000; valid_out = 4'b1111; dirty_out = 4'b0001; plru_out = 3'b000;
    exp_idle(S_COMPARE); step("t2_miss_cycle"); exp_misses++;
    plru_out = 3'b100; valid_out = 4'b1101;  // latched victim must not move
    exp_wb(0); step("t2_wb_wait");
    pmem_resp = 1'b1;
    exp_wb(0); step("t2_wb_resp");
    pmem_resp = 1'b0;
    exp_fill_wait(); step("t2_fill_wait");
    pmem_resp = 1'b1;
    exp_fill_done(0, plru_touch4(3'b100, 0)); step("t2_fill_resp_victim_q");
    pmem_resp = 1'b0;
    match = 4'b0001; valid_out = 4'b1111; dirty_out = 4'b0001; plru_out = 3'b111;
    exp_hit(0, 1'b1, plru_touch4(3'b111, 0)); step("t2_write_hit"); exp_hits++;
    check_counts("t2");

    // match on an invalid way is a miss; the invalid way 2 is the victim
    mem_write = 1'b0; mem_read = 1'b1;
    match = 4'b0100; valid_out = 4'b1011; dirty_out = 4'b0000; plru_out = 3'b000;
    exp_idle(S_COMPARE); step("t3_miss_cycle"); exp_misses++;
    pmem_resp = 1'b1;
    exp_fill_done(2, plru_touch4(3'b000, 2)); step("t3_fill_way2");
    pmem_resp = 1'b0;
    valid_out = 4'b1111; plru_out = 3'b100;
    exp_hit(2, 1'b0, plru_touch4(3'b100, 2)); step("t3_read_hit"); exp_hits++;
    check_counts("t3");

    // read and write together act as a write; hit on way 3
    mem_read = 1'b1; mem_write = 1'b1;
    match = 4'b1000; valid_out = 4'b1111; dirty_out = 4'b0000; plru_out = 3'b111;
    exp_hit(3, 1'b1, plru_touch4(3'b111, 3)); step("t4_write_hit_way3"); exp_hits++;

    // clean PLRU miss (way 1); request dropped during the fill
    mem_write = 1'b0; mem_read = 1'b1;
    match = 4'b0000; valid_out = 4'b1111; dirty_out = 4'b0000; plru_out = 3'b010;
    exp_idle(S_COMPARE); step("t5_miss_cycle"); exp_misses++;
    mem_read = 1'b0;
    exp_fill_wait(); step("t5_fill_wait_dropped");
    pmem_resp = 1'b1;
    exp_fill_done(1, plru_touch4(3'b010, 1)); step("t5_fill_resp");
    pmem_resp = 1'b0;
    exp_idle(S_COMPARE); step("t5_idle");
    check_counts("t5");

    // asynchronous reset in the middle of a writeback
    mem_read = 1'b1;
    match = 4'b0000; valid_out = 4'b1111; dirty_out = 4'b1111; plru_out = 3'b000;
    exp_idle(S_COMPARE); step("t6_miss_cycle"); exp_misses++;
    exp_wb(0); sample_out("t6_wb_before_reset");
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_pmem_write", 64'(pmem_write), 64'(0));
    check("t6_async_outputs", 64'(cur()), 64'(0));
    exp_hits = 0;
    exp_misses = 0;
    check_counts("t6_reset");
    tick();
    rst_n = 1'b1;
    mem_read = 1'b0;
    exp_idle(S_COMPARE); step("t6_after_release");

    // five read hits on way 1: the 2-bit counter pins at 3
    mem_read = 1'b1;
    match = 4'b0010; valid_out = 4'b1111; dirty_out = 4'b0000; plru_out = 3'b000;
    for (int i = 0; i < 5; i++) begin
      exp_hit(1, 1'b0, plru_touch4(3'b000, 1)); step("t7_hit"); exp_hits++;
      check_counts("t7");
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nway_cache_control.md
# nway_cache_control

Parametrised N-way set-associative, write-back, write-allocate cache controller FSM. It supersedes the fixed 2-way L1 controller and adds:
- tree pseudo-LRU replacement
- victim selection that prefers invalid ways
- a victim way latched for the whole miss
- saturating hit/miss counters

It sits between the CPU-side memory port and the physical-memory port, driving the per-way tag/data/valid/dirty arrays and the per-set PLRU array in the cache datapath.

## Interface
- WAYS, 4: associativity; power of two, 2..8.
- WAY_W, $clog2(WAYS): way index width (derived; not overridden).
- CNT_W, 16: width of each performance counter.

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_read / mem_write  in  1  CPU request; if both are high, treated as a write
- mem_resp  out  1  CPU request complete this cycle
- pmem_read / pmem_write  out  1  physical memory request
- pmem_resp  in  1  physical memory transfer complete
- match  in  WAYS  per-way tag compare (raw, not valid-qualified)
- valid_out / dirty_out  in  WAYS  per-way valid/dirty of indexed set
- plru_out  in  WAYS-1  PLRU tree bits of indexed set
- plru_in  out  WAYS-1  updated PLRU bits
- plru_load  out  1  write plru_in to indexed set
- data_load / tag_load / valid_load / dirty_load  out  WAYS  one-hot array writes
- valid_in / dirty_in  out  1  value written by valid_load / dirty_load
- way_sel  out  WAY_W  output data mux select
- write_array_sel  out  1  0 = CPU write data, 1 = pmem fill line
- pmem_address_sel  out  1  0 = CPU address, 1 = {victim tag, index}
- hit_count / miss_count  out  CNT_W  saturating counters

## Operation
- hit = |(match & valid_out); hit_way = lowest index with match & valid. A matching invalid way is a miss.
- Victim: lowest-index invalid way if any exist, else the PLRU tree victim.
- PLRU tree: bit 0 is the root; node i has children 2i+1 and 2i+2. A node value of 0 means the victim is in the lower-index half. An access to way w sets every node on w's path to point away from w.
- States (enum): S_COMPARE, S_WRITEBACK, S_FILL.
- S_COMPARE, no request: all outputs 0, stay.
- S_COMPARE, hit:
  - mem_resp=1, way_sel=hit_way, plru_load=1 with plru_in updated for hit_way.
  - On a write, additionally data_load[hit_way]=1, write_array_sel=0, dirty_in=1, dirty_load[hit_way]=1.
  - hit_count increments; stay in S_COMPARE.
- S_COMPARE, miss:
  - victim_q <= victim; miss_count increments.
  - If valid_out[victim] & dirty_out[victim], go to S_WRITEBACK; else go to S_FILL.
  - No pmem request is asserted in this cycle.
- S_WRITEBACK:
  - pmem_write=1, pmem_address_sel=1, way_sel=victim_q.
  - On pmem_resp, go to S_FILL.
- S_FILL:
  - pmem_read=1, pmem_address_sel=0.
  - On pmem_resp, in the same cycle: tag_load, data_load, valid_load and dirty_load at victim_q; write_array_sel=1, valid_in=1, dirty_in=0; plru_load=1 with plru_in updated for victim_q. Go to S_COMPARE.
  - The request then hits on the next cycle.
- A request dropped mid-miss does not abort the miss; writeback and fill complete normally.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset (asynchronous, rst_n low):
  - state=S_COMPARE, victim_q=0, hit_count=miss_count=0.
  - All outputs 0 while rst_n is low, including pmem_read and pmem_write, which deassert immediately mid-transaction.
- All outputs are combinational from state and inputs; registered state is limited to state, victim_q and the counters.
- Latency:
  - hit: mem_resp in the request cycle (0 wait).
  - clean miss: 1 + F + 1 cycles, where F is the number of pmem_read cycles up to and including pmem_resp.
  - dirty miss: 1 + W + F + 1 cycles, where W counts the pmem_write cycles up to and including pmem_resp.
- pmem_read/pmem_write are held high until the cycle pmem_resp is sampled and drop the following cycle. They are never high together.
- victim_q is stable from the S_COMPARE exit until the S_FILL exit, even if plru_out or valid_out change.

## Structure
- The cache_state_t enum lives in lc3b_types.
- The WAYS-generic PLRU logic is the sub-module plru_tree (combinational):
  - victim = f(plru_out)
  - plru_in = f(plru_out, access_way)
  - It is instantiated once; access_way is muxed between hit_way and victim_q.

## Test plan
- WAYS=4, all ways invalid, read miss → victim way 0, S_FILL; pmem_resp after 3 cycles → valid_load[0]=1, dirty_in=0, plru_in=3'b011; next cycle mem_resp=1, hit_count=1, miss_count=1.
- Set full, plru_out=3'b000, way 0 dirty, write miss → S_WRITEBACK with pmem_address_sel=1, way_sel=0; then S_FILL; then write hit with dirty_load[0]=1, dirty_in=1.
- match=4'b0100, valid_out=4'b1011 → treated as a miss; victim is way 2 (invalid), not PLRU-selected.
- Write hit on way 3 with mem_read=mem_write=1 → data_load=4'b1000, write_array_sel=0, mem_resp=1, plru_in bits 0 and 2 cleared.
- Assert rst_n=0 mid-S_WRITEBACK → pmem_write drops asynchronously, counters=0; after release, state=S_COMPARE.
- CNT_W=2, 5 hits → hit_count saturates at 2'b11.
